parity_filter: RTL and testbench

PARITY_FILTER -- requirements
Module: parity_filter

---
 rtl/parity_filter.sv | 107 ++++++++++
 tb/tb_parity_filter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_filter.sv
// Parity-checking pop stage between a FIFO and a downstream consumer.
// Good words pass through a one-entry register; bad words are dropped and counted.
module parity_filter #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter bit          PARITY_MODE       = 1'b0,  // 0: even, 1: odd
    parameter bit          PARITY_BIT_CHOICE = 1'b0,  // 0: MSB, 1: LSB
    parameter int unsigned ERR_CNT_WIDTH     = 8,
    parameter int unsigned ERR_BURST_MAX     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     pop_valid_i,
    input  logic [DATA_WIDTH-1:0]    pop_data_i,
    output logic                     pop_grant_o,
    input  logic                     grant_i,
    output logic                     valid_o,
    output logic [DATA_WIDTH-2:0]    data_o,
    input  logic                     clr_err_i,
    output logic                     err_pulse_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o,
    output logic                     burst_alarm_o
);

    localparam logic [7:0] BurstMax = 8'(ERR_BURST_MAX);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-2:0]    data_q, data_d;
    logic                     err_pulse_q, err_pulse_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [7:0]               burst_cnt_q, burst_cnt_d;
    logic                     alarm_q, alarm_d;

    logic                  bad;
    logic                  good_pop;
    logic                  bad_pop;
    logic [DATA_WIDTH-2:0] payload;

    assign bad         = ((^pop_data_i) != PARITY_MODE);
    assign pop_grant_o = pop_valid_i & (bad | (state_q == StEmpty) | grant_i);
    assign good_pop    = pop_grant_o & ~bad;
    assign bad_pop     = pop_grant_o & bad;
    assign payload     = PARITY_BIT_CHOICE ? pop_data_i[DATA_WIDTH-1:1]
                                           : pop_data_i[DATA_WIDTH-2:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StEmpty;
            data_q      <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            burst_cnt_q <= '0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            burst_cnt_q <= burst_cnt_d;
            alarm_q     <= alarm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (good_pop) begin
            state_d = StFull;
            data_d  = payload;
        end else if ((state_q == StFull) && grant_i) begin
            state_d = StEmpty;
        end
    end

    // Clear wins over a same-cycle bad pop for the counters, but the pulse still fires.
    always_comb begin
        err_pulse_d = bad_pop;
        err_count_d = err_count_q;
        burst_cnt_d = burst_cnt_q;
        alarm_d     = alarm_q;
        if (clr_err_i) begin
            err_count_d = '0;
            burst_cnt_d = '0;
            alarm_d     = 1'b0;
        end else if (bad_pop) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
            if (burst_cnt_q < BurstMax) begin
                burst_cnt_d = burst_cnt_q + 8'd1;
            end
            if (burst_cnt_d == BurstMax) begin
                alarm_d = 1'b1;
            end
        end else if (good_pop) begin
            burst_cnt_d = '0;
        end
    end

    assign valid_o       = (state_q == StFull);
    assign data_o        = data_q;
    assign err_pulse_o   = err_pulse_q;
    assign err_count_o   = err_count_q;
    assign burst_alarm_o = alarm_q;

endmodule

// File: tb/tb_parity_filter.sv
// Directed bench for parity_filter: default instance, a 2-bit counter instance,
// and an odd-parity LSB instance, all sharing one stimulus set.
module tb_parity_filter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic       grant;
    logic       clr_err;

    logic       a_pop_grant, a_valid, a_pulse, a_alarm;
    logic [6:0] a_data;
    logic [7:0] a_count;
    logic       s_pop_grant, s_valid, s_pulse, s_alarm;
    logic [6:0] s_data;
    logic [1:0] s_count;
    logic       o_pop_grant, o_valid, o_pulse, o_alarm;
    logic [6:0] o_data;
    logic [7:0] o_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_filter u_dut (
        .clk_i(clk), .rst_ni(rst_n), .pop_valid_i(pop_valid), .pop_data_i(pop_data),
        .pop_grant_o(a_pop_grant), .grant_i(grant), .valid_o(a_valid), .data_o(a_data),
        .clr_err_i(clr_err), .err_pulse_o(a_pulse), .err_count_o(a_count),
        .burst_alarm_o(a_alarm)
    );

    parity_filter #(.ERR_CNT_WIDTH(2)) u_dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .pop_valid_i(pop_valid), .pop_data_i(pop_data),
        .pop_grant_o(s_pop_grant), .grant_i(grant), .valid_o(s_valid), .data_o(s_data),
        .clr_err_i(clr_err), .err_pulse_o(s_pulse), .err_count_o(s_count),
        .burst_alarm_o(s_alarm)
    );

    parity_filter #(.PARITY_MODE(1'b1), .PARITY_BIT_CHOICE(1'b1)) u_dut_odd (
        .clk_i(clk), .rst_ni(rst_n), .pop_valid_i(pop_valid), .pop_data_i(pop_data),
        .pop_grant_o(o_pop_grant), .grant_i(grant), .valid_o(o_valid), .data_o(o_data),
        .clr_err_i(clr_err), .err_pulse_o(o_pulse), .err_count_o(o_count),
        .burst_alarm_o(o_alarm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pop_valid = 1'b0; pop_data = 8'h00; grant = 1'b0; clr_err = 1'b0;
        #3;
        checks++;
        if (a_valid !== 1'b0 || a_data !== 7'h00) begin
            errors++; $display("FAIL reset_data valid=%b data=%h exp 0/00", a_valid, a_data);
        end
        checks++;
        if (a_count !== 8'h00 || a_alarm !== 1'b0 || a_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_err count=%h alarm=%b pulse=%b exp 0", a_count, a_alarm, a_pulse);
        end
        #9 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_hold();
        pop_valid = 1'b1; pop_data = 8'h03; grant = 1'b0;
        #1;
        checks++;
        if (a_pop_grant !== 1'b1) begin
            errors++; $display("FAIL good_grant got %b exp 1", a_pop_grant);
        end
        tick();
        pop_valid = 1'b0;
        checks++;
        if (a_valid !== 1'b1 || a_data !== 7'h03) begin
            errors++; $display("FAIL good_load valid=%b data=%h exp 1/03", a_valid, a_data);
        end
        tick();
        tick();
        checks++;
        if (a_valid !== 1'b1 || a_data !== 7'h03) begin
            errors++; $display("FAIL good_hold valid=%b data=%h exp 1/03", a_valid, a_data);
        end
        grant = 1'b1;
        tick();
        grant = 1'b0;
        checks++;
        if (a_valid !== 1'b0) begin
            errors++; $display("FAIL good_drain valid=%b exp 0", a_valid);
        end
    endtask

    task automatic test_bad_drop();
        pop_valid = 1'b1; pop_data = 8'h05;
        tick();
        pop_data = 8'h01;
        #1;
        checks++;
        if (a_pop_grant !== 1'b1) begin
            errors++; $display("FAIL bad_grant got %b exp 1", a_pop_grant);
        end
        tick();
        pop_valid = 1'b0;
        checks++;
        if (a_pulse !== 1'b1 || a_count !== 8'd1) begin
            errors++; $display("FAIL bad_count pulse=%b count=%0d exp 1/1", a_pulse, a_count);
        end
        checks++;
        if (a_valid !== 1'b1 || a_data !== 7'h05) begin
            errors++; $display("FAIL bad_keep valid=%b data=%h exp 1/05", a_valid, a_data);
        end
        tick();
        checks++;
        if (a_pulse !== 1'b0) begin
            errors++; $display("FAIL bad_pulse_len pulse=%b exp 0", a_pulse);
        end
    endtask

    task automatic test_backpressure();
        pop_valid = 1'b1; pop_data = 8'h81; grant = 1'b0;
        #1;
        checks++;
        if (a_pop_grant !== 1'b0) begin
            errors++; $display("FAIL bp_grant got %b exp 0", a_pop_grant);
        end
        tick();
        checks++;
        if (a_data !== 7'h05) begin
            errors++; $display("FAIL bp_hold data=%h exp 05", a_data);
        end
        grant = 1'b1;
        #1;
        checks++;
        if (a_pop_grant !== 1'b1) begin
            errors++; $display("FAIL bp_release got %b exp 1", a_pop_grant);
        end
        tick();
        pop_valid = 1'b0;
        checks++;
        if (a_valid !== 1'b1 || a_data !== 7'h01 || a_count !== 8'd1) begin
            errors++;
            $display("FAIL bp_load valid=%b data=%h count=%0d exp 1/01/1", a_valid, a_data, a_count);
        end
        tick();
        grant = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        words = '{8'h03, 8'h06, 8'h0f};
        grant = 1'b1; pop_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pop_data = words[i];
            tick();
            checks++;
            if (a_valid !== 1'b1 || a_data !== words[i][6:0]) begin
                errors++;
                $display("FAIL b2b_%0d valid=%b data=%h exp 1/%h", i, a_valid, a_data, words[i][6:0]);
            end
        end
        pop_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (a_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_empty valid=%b exp 0", a_valid);
        end
    endtask

    task automatic test_burst();
        logic [7:0] run [7];
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (a_count !== 8'd0) begin
            errors++; $display("FAIL burst_clr count=%0d exp 0", a_count);
        end
        grant = 1'b1; pop_valid = 1'b1;
        run = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h03, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            pop_data = run[i];
            tick();
            if (i == 2) begin
                checks++;
                if (a_alarm !== 1'b0) begin
                    errors++; $display("FAIL burst_early alarm=%b exp 0", a_alarm);
                end
            end
        end
        checks++;
        if (a_alarm !== 1'b1) begin
            errors++; $display("FAIL burst_set alarm=%b exp 1", a_alarm);
        end
        pop_data = 8'h03;
        tick();
        checks++;
        if (a_alarm !== 1'b1 || a_count !== 8'd4) begin
            errors++; $display("FAIL burst_sticky alarm=%b count=%0d exp 1/4", a_alarm, a_count);
        end
        pop_valid = 1'b0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0; pop_valid = 1'b1;
        checks++;
        if (a_alarm !== 1'b0) begin
            errors++; $display("FAIL burst_clr_alarm alarm=%b exp 0", a_alarm);
        end
        run = '{8'h01, 8'h02, 8'h04, 8'h03, 8'h10, 8'h20, 8'h40};
        for (int i = 0; i < 7; i++) begin
            pop_data = run[i];
            tick();
        end
        pop_valid = 1'b0;
        checks++;
        if (a_alarm !== 1'b0 || a_count !== 8'd6) begin
            errors++; $display("FAIL burst_broken alarm=%b count=%0d exp 0/6", a_alarm, a_count);
        end
        tick();
        grant = 1'b0;
    endtask

    task automatic test_saturate();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0; pop_valid = 1'b1; pop_data = 8'h01; grant = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (s_count !== 2'd3 || a_count !== 8'd5) begin
            errors++; $display("FAIL sat_count sat=%0d main=%0d exp 3/5", s_count, a_count);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0; pop_valid = 1'b0;
        checks++;
        if (s_count !== 2'd0 || s_pulse !== 1'b1) begin
            errors++; $display("FAIL sat_clr count=%0d pulse=%b exp 0/1", s_count, s_pulse);
        end
        tick();
        grant = 1'b0;
    endtask

    task automatic test_reset_mid();
        pop_valid = 1'b1; pop_data = 8'h03; grant = 1'b0;
        tick();
        pop_valid = 1'b0;
        checks++;
        if (a_valid !== 1'b1) begin
            errors++; $display("FAIL rst_pre valid=%b exp 1", a_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || a_data !== 7'h00) begin
            errors++; $display("FAIL rst_async valid=%b data=%h exp 0/00", a_valid, a_data);
        end
        pop_valid = 1'b1;
        #1;
        checks++;
        if (a_pop_grant !== 1'b1) begin
            errors++; $display("FAIL rst_grant got %b exp 1", a_pop_grant);
        end
        #2 rst_n = 1'b1; pop_valid = 1'b0;
        tick();
        pop_valid = 1'b1; pop_data = 8'h03;
        tick();
        checks++;
        if (o_count !== 8'd1 || o_pulse !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL odd_drop count=%0d pulse=%b valid=%b exp 1/1/0", o_count, o_pulse, o_valid);
        end
        pop_data = 8'h07;
        tick();
        pop_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_data !== 7'h03) begin
            errors++; $display("FAIL odd_lsb valid=%b data=%h exp 1/03", o_valid, o_data);
        end
    endtask

    initial begin
        test_reset();
        test_good_hold();
        test_bad_drop();
        test_backpressure();
        test_back_to_back();
        test_burst();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
